// File: rtl/gcm_pkg.sv
// Shared GHASH constants, block-type codes and the engine state encoding.
package gcm_pkg;
  localparam int BLK_W = 128;
  localparam int LEN_W = 64;
  localparam logic [BLK_W-1:0] GHASH_R = 128'hE1000000000000000000000000000000;
  localparam logic BLK_AAD = 1'b0;
  localparam logic BLK_CT  = 1'b1;

  typedef enum logic [1:0] {IDLE, READY, MULT, DONE} ghash_state_t;
endpackage

// File: rtl/gf128_mul_step.sv
// Combinational slice of the bit-reflected GF(2^128) multiply: advances (Z, V)
// over BITS bits of X, most significant bit first.
module gf128_mul_step
  import gcm_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0]  x_bits,
  input  logic [BLK_W-1:0] z_in,
  input  logic [BLK_W-1:0] v_in,
  output logic [BLK_W-1:0] z_out,
  output logic [BLK_W-1:0] v_out
);
  logic [BLK_W-1:0] w_z;
  logic [BLK_W-1:0] w_v;

  always_comb begin
    w_z = z_in;
    w_v = v_in;
    for (int i = 0; i < BITS; i++) begin
      if (x_bits[BITS-1-i]) w_z = w_z ^ w_v;
      // Multiply V by x: shift toward vector bit 0, reduce when x^127 falls off.
      w_v = w_v[0] ? ((w_v >> 1) ^ GHASH_R) : (w_v >> 1);
    end
    z_out = w_z;
    v_out = w_v;
  end
endmodule

// File: rtl/gcm_ghash_core.sv
// Sequential GHASH engine: absorbs AAD then CT blocks, folds the length block.
// Optional macro GHASH_ORDER_CHECK_EN adds AAD/CT ordering and partial-block checks.
module gcm_ghash_core
  import gcm_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] h_in,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic         blk_type,
  input  logic [4:0]   blk_bytes,
  input  logic         final_valid,
  output logic         busy,
  output logic         tag_valid,
  output logic [127:0] ghash_out,
  output logic         err
);
  localparam int NCYC = BLK_W / BITS_PER_CYCLE;

  ghash_state_t     r_state, w_state_next;
  logic [BLK_W-1:0] r_h, r_y, r_x, r_z, r_v;
  logic [LEN_W-1:0] r_len_a, r_len_c;
  logic [7:0]       r_cnt;
  logic             r_fin, r_err;
  logic [BLK_W-1:0] w_z_step, w_v_step;
  logic [4:0]       w_bytes_eff;
  logic [LEN_W-1:0] w_len_inc;
  logic             w_bytes_bad, w_accept, w_final_go, w_last, w_err_set;

  assign w_bytes_bad = (blk_bytes == 5'd0) || (blk_bytes > 5'd16);
  assign w_bytes_eff = w_bytes_bad ? 5'd16 : blk_bytes;
  assign w_len_inc   = {56'd0, w_bytes_eff, 3'b000};
  assign w_accept    = (r_state == READY) && blk_valid;
  assign w_final_go  = (r_state == READY) && final_valid && !blk_valid;
  assign w_last      = (r_cnt == 8'(NCYC - 1));

  assign blk_ready = (r_state == READY);
  assign busy      = (r_state == MULT);
  assign tag_valid = (r_state == DONE);
  assign ghash_out = r_y;
  assign err       = r_err;

  gf128_mul_step #(.BITS(BITS_PER_CYCLE)) u_step (
    .x_bits (r_x[BLK_W-1 -: BITS_PER_CYCLE]),
    .z_in   (r_z),
    .v_in   (r_v),
    .z_out  (w_z_step),
    .v_out  (w_v_step)
  );

`ifdef GHASH_ORDER_CHECK_EN
  logic r_seen_ct, r_short_aad, r_short_ct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen_ct   <= 1'b0;
      r_short_aad <= 1'b0;
      r_short_ct  <= 1'b0;
    end else if (start) begin
      r_seen_ct   <= 1'b0;
      r_short_aad <= 1'b0;
      r_short_ct  <= 1'b0;
    end else if (w_accept) begin
      if (blk_type == BLK_CT) begin
        r_seen_ct  <= 1'b1;
        r_short_ct <= (w_bytes_eff != 5'd16);
      end else begin
        r_short_aad <= (w_bytes_eff != 5'd16);
      end
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = IDLE;
      READY:   if (blk_valid || final_valid) w_state_next = MULT;
      MULT:    if (w_last) w_state_next = r_fin ? DONE : READY;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
    if (start) w_state_next = READY;
  end

  always_comb begin
    w_err_set = 1'b0;
    if ((r_state == READY) && blk_valid && final_valid) w_err_set = 1'b1;
    if ((r_state != READY) && final_valid) w_err_set = 1'b1;
    if ((r_state != READY) && (r_state != IDLE) && blk_valid) w_err_set = 1'b1;
    if (w_accept && w_bytes_bad) w_err_set = 1'b1;
`ifdef GHASH_ORDER_CHECK_EN
    if (w_accept && (blk_type == BLK_AAD) && r_seen_ct) w_err_set = 1'b1;
    if (w_accept && (((blk_type == BLK_AAD) && r_short_aad) ||
                     ((blk_type == BLK_CT) && r_short_ct))) w_err_set = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_y     <= '0;
      r_x     <= '0;
      r_z     <= '0;
      r_v     <= '0;
      r_len_a <= '0;
      r_len_c <= '0;
      r_cnt   <= '0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (start) begin
        r_h     <= h_in;
        r_y     <= '0;
        r_len_a <= '0;
        r_len_c <= '0;
        r_cnt   <= '0;
        r_fin   <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        if (w_err_set) r_err <= 1'b1;
        if (w_accept || w_final_go) begin
          r_x   <= r_y ^ (w_accept ? blk_data : {r_len_a, r_len_c});
          r_z   <= '0;
          r_v   <= r_h;
          r_cnt <= '0;
          r_fin <= w_final_go;
        end
        if (w_accept) begin
          if (blk_type == BLK_CT) r_len_c <= r_len_c + w_len_inc;
          else                    r_len_a <= r_len_a + w_len_inc;
        end
        if (r_state == MULT) begin
          r_x   <= r_x << BITS_PER_CYCLE;
          r_z   <= w_z_step;
          r_v   <= w_v_step;
          r_cnt <= r_cnt + 8'd1;
          if (w_last) r_y <= w_z_step;
        end
      end
    end
  end
endmodule

// File: tb/tb_gcm_ghash_core.sv
// Self-checking bench for gcm_ghash_core: directed GCM vectors plus random
// messages checked against a polynomial-arithmetic GHASH model.
module tb_gcm_ghash_core;
  logic         clk = 1'b0;
  logic         rst, start, blk_valid, blk_type, final_valid;
  logic [127:0] h_in, blk_data;
  logic [4:0]   blk_bytes;
  logic         blk_ready, busy, tag_valid, err;
  logic [127:0] ghash_out;

  int total = 0;
  int bad   = 0;

  logic [127:0] m_blocks[$];
  logic [63:0]  m_la, m_lc;

  localparam logic [127:0] H1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C1 = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] S1 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] H3 = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] A3 = 128'hfeedfacedeadbeeffeedfacedeadbeef;
  localparam logic [127:0] C3 = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] S3 = 128'hb27d0f3ba267726f9a55f2d9bb4fa11d;

  gcm_ghash_core #(.BITS_PER_CYCLE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .h_in(h_in),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_type(blk_type), .blk_bytes(blk_bytes), .final_valid(final_valid),
    .busy(busy), .tag_valid(tag_valid), .ghash_out(ghash_out), .err(err)
  );

  always #5 clk = ~clk;

  // Spec bit i (vector bit 127-i) is the coefficient of x^i; multiply and
  // reduce modulo x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p;
    logic [127:0] r;
    p = '0;
    for (int i = 0; i < 128; i++)
      if (a[127-i])
        for (int j = 0; j < 128; j++)
          if (b[127-j]) p[i+j] = ~p[i+j];
    for (int k = 254; k >= 128; k--)
      if (p[k]) begin
        p[k]     = 1'b0;
        p[k-128] = ~p[k-128];
        p[k-127] = ~p[k-127];
        p[k-126] = ~p[k-126];
        p[k-121] = ~p[k-121];
      end
    for (int i = 0; i < 128; i++) r[127-i] = p[i];
    return r;
  endfunction

  function automatic logic [127:0] model_s(input logic [127:0] h);
    logic [127:0] y;
    y = '0;
    foreach (m_blocks[i]) y = gf_mul(y ^ m_blocks[i], h);
    return gf_mul(y ^ {m_la, m_lc}, h);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] h);
    h_in  = h;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_blocks.delete();
    m_la = '0;
    m_lc = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!blk_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_timeout", 128'(blk_ready), 128'd1);
  endtask

  task automatic wait_tag();
    int n = 0;
    while (!tag_valid && n < 200) begin
      tick();
      n++;
    end
    chk("tag_timeout", 128'(tag_valid), 128'd1);
  endtask

  task automatic send_block(input logic [127:0] d, input logic t, input logic [4:0] nb);
    int eff;
    wait_ready();
    blk_data  = d;
    blk_type  = t;
    blk_bytes = nb;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    eff = (nb == 0 || nb > 16) ? 16 : int'(nb);
    m_blocks.push_back(d);
    if (t) m_lc = m_lc + 64'(8 * eff);
    else   m_la = m_la + 64'(8 * eff);
    $display("block type=%0d bytes=%0d data=%h", t, nb, d);
  endtask

  task automatic do_final();
    wait_ready();
    final_valid = 1'b1;
    tick();
    final_valid = 1'b0;
    wait_tag();
    $display("final ghash_out=%h err=%0d", ghash_out, err);
  endtask

  initial begin
    logic [127:0] h, d0, d1, ones, mask;
    logic         exp_err;
    int           n, cyc, n_acc, busy_cnt, na, nc, nb;
    int           acc_cyc[2];

    rst = 1'b1; start = 1'b0; blk_valid = 1'b0; final_valid = 1'b0;
    blk_type = 1'b0; blk_bytes = 5'd16; h_in = '0; blk_data = '0;
    ones = '1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 128'(blk_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_tag", 128'(tag_valid), 128'd0);
    chk("rst_ghash", ghash_out, 128'd0);
    chk("rst_err", 128'(err), 128'd0);

    // GCM test case 2: one ciphertext block
    do_start(H1);
    send_block(C1, 1'b1, 5'd16);
    wait_ready();
    chk("tv1_running_y", ghash_out, gf_mul(C1, H1));
    do_final();
    chk("tv1_ghash", ghash_out, S1);
    chk("tv1_err", 128'(err), 128'd0);

    // Final only: S = 0, tag 17 cycles after the pulse
    do_start(H1);
    final_valid = 1'b1;
    tick();
    final_valid = 1'b0;
    n = 1;
    while (!tag_valid && n < 200) begin
      tick();
      n++;
    end
    chk("final_only_latency", 128'(n), 128'd17);
    chk("final_only_ghash", ghash_out, 128'd0);

    // AAD then CT
    do_start(H3);
    send_block(A3, 1'b0, 5'd16);
    send_block(C3, 1'b1, 5'd16);
    do_final();
    chk("tv3_ghash", ghash_out, S3);
    chk("tv3_model", ghash_out, model_s(H3));
    chk("tv3_err", 128'(err), 128'd0);
    final_valid = 1'b1;
    tick();
    final_valid = 1'b0;
    chk("final_in_done_err", 128'(err), 128'd1);
    chk("final_in_done_tag", 128'(tag_valid), 128'd1);

    // Back-to-back blk_valid held high
    h = rnd128(); d0 = rnd128(); d1 = rnd128();
    do_start(h);
    blk_data = d0; blk_type = 1'b1; blk_bytes = 5'd16; blk_valid = 1'b1;
    cyc = 0; n_acc = 0; busy_cnt = 0;
    while (n_acc < 2 && cyc < 100) begin
      if (blk_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end else if (busy) begin
        busy_cnt++;
      end
      tick();
      cyc++;
      if (n_acc == 1) blk_data = d1;
      if (n_acc == 2) blk_valid = 1'b0;
    end
    blk_valid = 1'b0;
    $display("back-to-back accepts=%0d gap=%0d busy=%0d", n_acc, acc_cyc[1] - acc_cyc[0], busy_cnt);
    chk("b2b_accepts", 128'(n_acc), 128'd2);
    chk("b2b_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'd17);
    chk("b2b_busy_cycles", 128'(busy_cnt), 128'd16);
    m_blocks.push_back(d0);
    m_blocks.push_back(d1);
    m_lc = 64'd256;
    do_final();
    chk("b2b_ghash", ghash_out, model_s(h));
    chk("b2b_err", 128'(err), 128'd1);

    // Reset during the 5th multiply cycle, then clean re-run
    do_start(H1);
    wait_ready();
    blk_data = C1; blk_type = 1'b1; blk_bytes = 5'd16; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 128'(blk_ready), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_tag", 128'(tag_valid), 128'd0);
    chk("midrst_ghash", ghash_out, 128'd0);
    chk("midrst_err", 128'(err), 128'd0);
    do_start(H1);
    send_block(C1, 1'b1, 5'd16);
    do_final();
    chk("rerun_ghash", ghash_out, S1);

    // blk_bytes = 0 is treated as a full block and flagged
    h = rnd128();
    do_start(h);
    send_block(rnd128(), 1'b1, 5'd0);
    chk("bytes0_err", 128'(err), 128'd1);
    do_final();
    chk("bytes0_ghash", ghash_out, model_s(h));

    // blk_valid and final_valid together: block taken, final dropped
    h = rnd128(); d0 = rnd128();
    do_start(h);
    blk_data = d0; blk_type = 1'b0; blk_bytes = 5'd16;
    blk_valid = 1'b1; final_valid = 1'b1;
    tick();
    blk_valid = 1'b0; final_valid = 1'b0;
    m_blocks.push_back(d0);
    m_la = 64'd128;
    chk("both_busy", 128'(busy), 128'd1);
    chk("both_err", 128'(err), 128'd1);
    wait_ready();
    chk("both_no_tag", 128'(tag_valid), 128'd0);
    do_final();
    chk("both_ghash", ghash_out, model_s(h));

    // CT followed by AAD: flagged only with the ordering check compiled in
    h = rnd128();
    do_start(h);
    send_block(rnd128(), 1'b1, 5'd16);
    send_block(rnd128(), 1'b0, 5'd16);
    do_final();
`ifdef GHASH_ORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    chk("order_err", 128'(err), 128'(exp_err));
    chk("order_ghash", ghash_out, model_s(h));
    do_start(h);
    chk("start_clears_err", 128'(err), 128'd0);

    // Random legal messages; only the last block of each type may be short
    for (int it = 0; it < 6; it++) begin
      h = rnd128();
      na = $urandom_range(0, 2);
      nc = $urandom_range(0, 3);
      do_start(h);
      for (int i = 0; i < na; i++) begin
        nb = (i == na - 1) ? $urandom_range(1, 16) : 16;
        mask = ones << (8 * (16 - nb));
        send_block(rnd128() & mask, 1'b0, 5'(nb));
      end
      for (int i = 0; i < nc; i++) begin
        nb = (i == nc - 1) ? $urandom_range(1, 16) : 16;
        mask = ones << (8 * (16 - nb));
        send_block(rnd128() & mask, 1'b1, 5'(nb));
      end
      do_final();
      chk($sformatf("rand%0d_ghash", it), ghash_out, model_s(h));
      chk($sformatf("rand%0d_err", it), 128'(err), 128'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
